// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and instruction-stream output handshakes of the encoder
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_encoding;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  modport master (
    output in_valid, in_encoding, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );
  modport slave (
    input  in_valid, in_encoding, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields + immediate into instruction words queued in a FIFO; IMM_RANGE_CHECK_EN rejects unencodable immediates
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  instr_encoder_if.slave   bus,
  output logic [ERR_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][31:0] mem_q, mem_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic [31:0]            last_q, last_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [31:0]            enc, imm;
  logic [2:0]             e;
  logic                   accept, push, pop, bad, reject;
  assign e   = bus.in_encoding;
  assign imm = bus.in_imm;
  // pack fields into the instruction word selected by the format code
  always_comb
    enc = e == 3'd0 ? {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
          e == 3'd1 ? {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
          e == 3'd2 ? {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode} :
          e == 3'd3 ? {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode} :
          e == 3'd4 ? {imm[31:12], bus.in_rd, bus.in_opcode} :
                      {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
`ifdef IMM_RANGE_CHECK_EN
  // immediate must sign-extend from the format's top bit; B/J offsets must be even
  always_comb
    bad = (e == 3'd1 || e == 3'd2) ? !(&imm[31:11] || ~|imm[31:11]) :
          e == 3'd3 ? !(&imm[31:12] || ~|imm[31:12]) || imm[0] :
          e == 3'd5 ? !(&imm[31:20] || ~|imm[31:20]) || imm[0] :
          e == 3'd4 ? |imm[11:0] : 1'b0;
`else
  // without the checker, out-of-range immediates are truncated by the packing above
  always_comb bad = 1'b0;
`endif
  assign bus.in_ready  = cnt_q != (AW+1)'(DEPTH);
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_instr = bus.out_valid ? mem_q[rd_q] : last_q;
  assign err_count     = err_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign reject        = e > 3'd5 || bad;
  assign push          = accept && !reject;
  assign pop           = bus.out_valid && bus.out_ready;
  // FIFO bookkeeping, remembered head for the empty case, saturating reject counter
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = enc;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    last_d = pop ? mem_q[rd_q] : last_q;
    err_d  = (accept && reject && err_q != '1) ? err_q + 1'b1 : err_q;
  end
  // state registers; reset discards queued words and clears the counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      err_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a scoreboard queue checked by an output monitor
module tb_instr_encoder;
  typedef struct {
    logic [31:0] w;
    logic [2:0]  f;
    logic [31:0] imm;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] err_count;
  int nvec = 0;
  int nfail = 0;
  int exp_err = 0;
  exp_t q[$];
  exp_t mon_e;
  instr_encoder_if bus ();
  instr_encoder #(.DEPTH(4), .ERR_W(8)) dut (.clk(clk), .reset_n(rst_n), .bus(bus), .err_count(err_count));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] dec_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction
  function automatic logic [31:0] dec_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  task automatic send(input logic [2:0] enc, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input bit wr, input logic [31:0] w);
    int n = 0;
    bus.in_encoding = enc; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (wr) q.push_back('{w: w, f: enc, imm: imm});
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1 check("drain_left", 32'(q.size()), 32'd0);
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_out: got %h, required no output", bus.out_instr);
      end else begin
        mon_e = q.pop_front();
        check("out_instr", bus.out_instr, mon_e.w);
        if (mon_e.f == 3'd2) check("s_roundtrip", dec_s(bus.out_instr), mon_e.imm);
        if (mon_e.f == 3'd3) check("b_roundtrip", dec_b(bus.out_instr), mon_e.imm);
      end
    end
  initial begin
    bus.in_valid = 1'b0; bus.in_encoding = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
    #5;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    #18 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("no_bypass", 32'(bus.out_valid), 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
    check("i_latency_valid", 32'(bus.out_valid), 32'd1);
    check("i_latency_word", bus.out_instr, 32'h00500093);
    send(3'd2, 7'h23, 5'd9, 5'd3, 5'd2, 3'd2, 7'h55, -32'sd4, 1, 32'hFE21AE23);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8, 1, 32'hFE000CE3);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1, 32'h402081B3);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1, 32'h008000EF);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1, 32'hFFDFF06F);
    drain();
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0, 32'd0);
    exp_err = 1;
    check("illegal_err", 32'(err_count), 32'(exp_err));
    check("illegal_no_out", 32'(bus.out_valid), 32'd0);
`ifdef IMM_RANGE_CHECK_EN
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'd0);
    exp_err = 2;
    check("range_no_out", 32'(bus.out_valid), 32'd0);
`else
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h80000093);
`endif
    check("range_err", 32'(err_count), 32'(exp_err));
    drain();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1, (32'(k) << 20) | 32'h93);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("full_hold_ready", 32'(bus.in_ready), 32'd0);
      check("stall_head", bus.out_instr, 32'h00100093);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("pop_in_ready", 32'(bus.in_ready), 32'd1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
    check("refull_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 6; k <= 8; k++) send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1, (32'(k) << 20) | 32'h93);
    drain();
    check("empty_hold", bus.out_instr, 32'h00800093);
    for (int k = 0; k < 260; k++) send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 32'd0);
    check("err_saturate", 32'(err_count), 32'd255);
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(3'd4, 7'h37, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000 * k, 1, (32'h1000 * k) | (32'(k) << 7) | 32'h37);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_instr", bus.out_instr, 32'd0);
    q.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1, 32'h002081B3);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
